// File: rtl/regfile_wb_writer.sv
// Writeback-side driver of the register file write port: merges ALU and load results
// into a small in-order FIFO and retires one write per cycle to the regfile.
module regfile_wb_writer #(
    parameter int DEPTH  = 4,
    parameter int REG_W  = 32,
    parameter int ADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [ADDR_W-1:0]        mem_waddr,
    input  logic [REG_W-1:0]         mem_wdata,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [ADDR_W-1:0]        alu_waddr,
    input  logic [REG_W-1:0]         alu_wdata,
    output logic                     we,
    output logic [ADDR_W-1:0]        waddr,
    output logic [REG_W-1:0]         wdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addrMem_q [DEPTH];
    logic [REG_W-1:0]  dataMem_q [DEPTH];

    logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [CNT_W-1:0]  free;
    logic              memHasWrite;
    logic              memPush;
    logic              aluPush;
    logic              pop;
    logic [CNT_W-1:0]  pushCnt;
    logic [PTR_W-1:0]  aluSlot;

    // Credit is taken from the registered count only, so a same-cycle pop never
    // frees a slot early; the load unit keeps priority for the last free slot.
    always_comb begin
        free        = CNT_W'(DEPTH) - count_q;
        memHasWrite = mem_valid && (mem_waddr != '0);
        mem_ready   = rst && !flush && (free >= CNT_W'(1));
        alu_ready   = rst && !flush &&
                      ((free >= CNT_W'(2)) || ((free == CNT_W'(1)) && !memHasWrite));
        memPush     = mem_valid && mem_ready && (mem_waddr != '0);
        aluPush     = alu_valid && alu_ready && (alu_waddr != '0);
        pop         = (count_q != '0);
        pushCnt     = CNT_W'(memPush) + CNT_W'(aluPush);
        aluSlot     = wrPtr_q + PTR_W'(memPush);
    end

    always_comb begin
        count_d = count_q;
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        if (flush) begin
            count_d = '0;
            rdPtr_d = '0;
            wrPtr_d = '0;
        end else begin
            count_d = count_q + pushCnt - CNT_W'(pop);
            rdPtr_d = rdPtr_q + PTR_W'(pop);
            wrPtr_d = wrPtr_q + PTR_W'(pushCnt);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            rdPtr_q <= '0;
            wrPtr_q <= '0;
        end else begin
            count_q <= count_d;
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
        end
    end

    // The load entry always lands ahead of the ALU entry when both arrive together.
    always_ff @(posedge clk) begin
        if (memPush) begin
            addrMem_q[wrPtr_q] <= mem_waddr;
            dataMem_q[wrPtr_q] <= mem_wdata;
        end
        if (aluPush) begin
            addrMem_q[aluSlot] <= alu_waddr;
            dataMem_q[aluSlot] <= alu_wdata;
        end
    end

    always_comb begin
        we    = pop;
        waddr = pop ? addrMem_q[rdPtr_q] : '0;
        wdata = pop ? dataMem_q[rdPtr_q] : '0;
        count = count_q;
    end

    countBound: assert property (@(posedge clk) disable iff (!rst) count_q <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_regfile_wb_writer.sv
// Self-checking bench for regfile_wb_writer: a negedge scoreboard tracks every accepted
// write and its expected retirement, while scenario tasks check timing-specific points.
module tb_regfile_wb_writer;

    localparam int DEPTH  = 4;
    localparam int REG_W  = 32;
    localparam int ADDR_W = 5;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [REG_W-1:0]  d;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_waddr;
    logic [REG_W-1:0]  mem_wdata;
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_waddr;
    logic [REG_W-1:0]  alu_wdata;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [REG_W-1:0]  wdata;
    logic [2:0]        count;

    wr_t expQ[$];
    int  checks = 0;
    int  passes = 0;

    regfile_wb_writer #(.DEPTH(DEPTH), .REG_W(REG_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
        .we(we), .waddr(waddr), .wdata(wdata), .count(count)
    );

    always #5 clk = ~clk;

    // Scoreboard: the queue length is the expected registered count; retire first,
    // then record this cycle's handshakes, which land at the coming edge.
    always @(negedge clk) begin
        int  sz;
        int  free;
        bit  expMemRdy;
        bit  expAluRdy;
        wr_t e;
        if (!rst) begin
            expQ.delete();
            checks++;
            if (count !== 3'd0 || we !== 1'b0 || mem_ready !== 1'b0 || alu_ready !== 1'b0)
                $display("[TB] FAIL reset_hold: count=%0d we=%b mrdy=%b ardy=%b, required 0 0 0 0",
                         count, we, mem_ready, alu_ready);
            else passes++;
        end else begin
            sz   = expQ.size();
            free = DEPTH - sz;
            checks++;
            if (count !== 3'(sz)) $display("[TB] FAIL sb_count: got %0d, required %0d", count, sz);
            else passes++;
            checks++;
            if (we !== (sz != 0)) $display("[TB] FAIL sb_we: got %b, required %b", we, (sz != 0));
            else passes++;
            if (sz != 0) begin
                e = expQ.pop_front();
                checks++;
                if (waddr !== e.a || wdata !== e.d)
                    $display("[TB] FAIL sb_write: got x%0d=%h, required x%0d=%h", waddr, wdata, e.a, e.d);
                else passes++;
            end
            expMemRdy = !flush && (free >= 1);
            expAluRdy = !flush && ((free >= 2) || (free == 1 && !(mem_valid && mem_waddr != 0)));
            checks++;
            if (mem_ready !== expMemRdy || alu_ready !== expAluRdy)
                $display("[TB] FAIL sb_ready: got mem=%b alu=%b, required mem=%b alu=%b",
                         mem_ready, alu_ready, expMemRdy, expAluRdy);
            else passes++;
            if (flush) expQ.delete();
            else begin
                if (mem_valid && expMemRdy && mem_waddr != 0) expQ.push_back('{a: mem_waddr, d: mem_wdata});
                if (alu_valid && expAluRdy && alu_waddr != 0) expQ.push_back('{a: alu_waddr, d: alu_wdata});
            end
        end
    end

    task automatic idleInputs();
        mem_valid = 1'b0; mem_waddr = '0; mem_wdata = '0;
        alu_valid = 1'b0; alu_waddr = '0; alu_wdata = '0;
        flush     = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        mem_valid = 1'b1; mem_waddr = 5'd1; mem_wdata = 32'h0000_0101;
        alu_valid = 1'b1; alu_waddr = 5'd2; alu_wdata = 32'h0000_0202;
        @(posedge clk); #1;
        mem_waddr = 5'd3; mem_wdata = 32'h0000_0303;
        alu_waddr = 5'd4; alu_wdata = 32'h0000_0404;
        @(posedge clk); #1;
        idleInputs();
        checks++;
        if (count !== 3'd3) $display("[TB] FAIL reset_prefill: count=%0d, required 3", count);
        else passes++;
        #1 rst = 1'b0;
        expQ.delete();
        #1;
        checks++;
        if (count !== 3'd0 || we !== 1'b0 || waddr !== 5'd0 || wdata !== 32'd0)
            $display("[TB] FAIL reset_async: count=%0d we=%b waddr=%0d wdata=%h, required all 0",
                     count, we, waddr, wdata);
        else passes++;
        checks++;
        if (mem_ready !== 1'b0 || alu_ready !== 1'b0)
            $display("[TB] FAIL reset_ready: mem=%b alu=%b, required 0 0", mem_ready, alu_ready);
        else passes++;
        @(posedge clk);
        @(posedge clk); #1 rst = 1'b1;
    endtask

    task automatic test_latency();
        @(posedge clk); #1;
        alu_valid = 1'b1; alu_waddr = 5'd5; alu_wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        idleInputs();
        checks++;
        if (we !== 1'b1 || waddr !== 5'd5 || wdata !== 32'hDEAD_BEEF)
            $display("[TB] FAIL latency_write: we=%b x%0d=%h, required 1 x5=deadbeef", we, waddr, wdata);
        else passes++;
        @(posedge clk); #1;
        checks++;
        if (count !== 3'd0 || we !== 1'b0)
            $display("[TB] FAIL latency_drain: count=%0d we=%b, required 0 0", count, we);
        else passes++;
    endtask

    task automatic test_dual_push();
        @(posedge clk); #1;
        mem_valid = 1'b1; mem_waddr = 5'd3; mem_wdata = 32'h11;
        alu_valid = 1'b1; alu_waddr = 5'd4; alu_wdata = 32'h22;
        @(posedge clk); #1;
        idleInputs();
        checks++;
        if (count !== 3'd2 || waddr !== 5'd3 || wdata !== 32'h11)
            $display("[TB] FAIL dual_first: count=%0d x%0d=%h, required 2 x3=11", count, waddr, wdata);
        else passes++;
        @(posedge clk); #1;
        checks++;
        if (count !== 3'd1 || waddr !== 5'd4 || wdata !== 32'h22)
            $display("[TB] FAIL dual_second: count=%0d x%0d=%h, required 1 x4=22", count, waddr, wdata);
        else passes++;
        @(posedge clk); #1;
        checks++;
        if (count !== 3'd0) $display("[TB] FAIL dual_drain: count=%0d, required 0", count);
        else passes++;
    endtask

    task automatic test_zero_addr();
        @(posedge clk); #1;
        alu_valid = 1'b1; alu_waddr = 5'd0; alu_wdata = 32'hFFFF;
        #1;
        checks++;
        if (alu_ready !== 1'b1) $display("[TB] FAIL zero_ready: alu_ready=%b, required 1", alu_ready);
        else passes++;
        @(posedge clk); #1;
        idleInputs();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (we !== 1'b0 || count !== 3'd0)
                $display("[TB] FAIL zero_discard: we=%b count=%0d, required 0 0", we, count);
            else passes++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        int memIdx  = 0;
        int aluIdx  = 0;
        int aluDrop = -1;
        int memDrop = -1;
        int waited  = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            mem_valid = 1'b1; mem_waddr = 5'(1 + memIdx);  mem_wdata = 32'hA000_0000 + 32'(memIdx);
            alu_valid = 1'b1; alu_waddr = 5'(16 + aluIdx); alu_wdata = 32'hB000_0000 + 32'(aluIdx);
            #1;
            checks++;
            if (count > 3'd4) $display("[TB] FAIL b2b_bound: count=%0d, required <= 4", count);
            else passes++;
            if (!alu_ready && aluDrop < 0) aluDrop = c;
            if (!mem_ready && memDrop < 0) memDrop = c;
            if (mem_ready) memIdx++;
            if (alu_ready) aluIdx++;
        end
        @(posedge clk); #1;
        idleInputs();
        checks++;
        if (aluDrop < 0 || (memDrop >= 0 && memDrop <= aluDrop))
            $display("[TB] FAIL b2b_priority: aluDrop=%0d memDrop=%0d, required alu first", aluDrop, memDrop);
        else passes++;
        while (count !== 3'd0 && waited < 10) begin
            @(posedge clk); #1;
            waited++;
        end
        checks++;
        if (count !== 3'd0) $display("[TB] FAIL b2b_drain: count=%0d after %0d cycles, required 0", count, waited);
        else passes++;
    endtask

    task automatic test_flush();
        @(posedge clk); #1;
        mem_valid = 1'b1; mem_waddr = 5'd9;  mem_wdata = 32'h99;
        alu_valid = 1'b1; alu_waddr = 5'd10; alu_wdata = 32'hAA;
        @(posedge clk); #1;
        mem_waddr = 5'd11; mem_wdata = 32'hBB;
        alu_waddr = 5'd12; alu_wdata = 32'hCC;
        flush = 1'b1;
        #1;
        checks++;
        if (mem_ready !== 1'b0 || alu_ready !== 1'b0 || count !== 3'd2)
            $display("[TB] FAIL flush_ready: mem=%b alu=%b count=%0d, required 0 0 2", mem_ready, alu_ready, count);
        else passes++;
        @(posedge clk); #1;
        idleInputs();
        checks++;
        if (we !== 1'b0 || count !== 3'd0)
            $display("[TB] FAIL flush_clear: we=%b count=%0d, required 0 0", we, count);
        else passes++;
        @(posedge clk); #1;
        alu_valid = 1'b1; alu_waddr = 5'd7; alu_wdata = 32'h77;
        @(posedge clk); #1;
        idleInputs();
        checks++;
        if (we !== 1'b1 || waddr !== 5'd7 || wdata !== 32'h77)
            $display("[TB] FAIL flush_after: we=%b x%0d=%h, required 1 x7=77", we, waddr, wdata);
        else passes++;
    endtask

    initial begin
        rst = 1'b0;
        idleInputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        test_reset();
        test_latency();
        test_dual_push();
        test_zero_addr();
        test_back_to_back();
        test_flush();
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (expQ.size() != 0) $display("[TB] FAIL final_empty: %0d writes never retired, required 0", expQ.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
